// File: rtl/fetch_pkg.sv
// Shared defaults and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned IM_DEPTH_DEF = 1024;
  localparam int unsigned FQ_DEPTH_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/fetch_imem.sv
// Instruction memory: one synchronous read port, one write port, read-before-write.
module fetch_imem
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned IM_DEPTH = IM_DEPTH_DEF
) (
  input  logic                        CLK,
  input  logic                        re,
  input  logic [$clog2(IM_DEPTH)-1:0] raddr,
  input  logic                        we,
  input  logic [$clog2(IM_DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]             wdata,
  output logic [XLEN-1:0]             rdata
);

  logic [XLEN-1:0] mem [IM_DEPTH];

  // Write and read on the same edge; a colliding read sees the old word.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC, one-deep read pipeline into imem, and a small fetch queue toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     IM_DEPTH = IM_DEPTH_DEF,
  parameter int unsigned     FQ_DEPTH = FQ_DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            im_we,
  input  logic [XLEN-1:0] im_waddr,
  input  logic [XLEN-1:0] im_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_npc,
  output logic [XLEN-1:0] out_ins
);

  localparam int unsigned     AW  = $clog2(IM_DEPTH);
  localparam int unsigned     QW  = $clog2(FQ_DEPTH);
  localparam int unsigned     CW  = QW + 1;
  localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [XLEN-1:0] rdata;

  logic [XLEN-1:0] q_pc  [FQ_DEPTH];
  logic [XLEN-1:0] q_ins [FQ_DEPTH];
  logic [QW-1:0]   wptr;
  logic [QW-1:0]   rptr;
  logic [CW-1:0]   count;

  logic            flush;
  logic            issue;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_kept;
  logic [CW-1:0]   count_nxt;
  logic [QW-1:0]   rptr_nxt;
  logic            valid_nxt;
  logic [XLEN-1:0] head_pc_nxt;
  logic [XLEN-1:0] head_ins_nxt;

  // Address bits below word alignment and above the memory index are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{redirect_pc[1:0], im_waddr[XLEN-1:AW+2], im_waddr[1:0]};

  // Reads are only issued when the queue is guaranteed room for the returning word.
  assign flush = RST || redirect_valid;
  assign issue = !flush && ((count + CW'(inflight)) < CW'(FQ_DEPTH));
  assign push  = inflight && !flush;
  assign pop   = out_valid && out_ready;

  fetch_imem #(
    .XLEN     (XLEN),
    .IM_DEPTH (IM_DEPTH)
  ) u_imem (
    .CLK   (CLK),
    .re    (issue),
    .raddr (pc[AW+1:2]),
    .we    (im_we),
    .waddr (im_waddr[AW+1:2]),
    .wdata (im_wdata),
    .rdata (rdata)
  );

  // Next queue occupancy and the entry that will sit at the head after this edge.
  always_comb begin
    count_kept   = count - CW'(pop);
    count_nxt    = count_kept + CW'(push);
    rptr_nxt     = pop ? rptr + QW'(1) : rptr;
    valid_nxt    = 1'b0;
    head_pc_nxt  = '0;
    head_ins_nxt = '0;
    if (!flush && (count_nxt != '0)) begin
      valid_nxt = 1'b1;
      if (count_kept == '0) begin
        head_pc_nxt  = inflight_pc;
        head_ins_nxt = rdata;
      end else begin
        head_pc_nxt  = q_pc[rptr_nxt];
        head_ins_nxt = q_ins[rptr_nxt];
      end
    end
  end

  // Fetch PC, in-flight read tracking and queue pointers; redirect flushes everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + INC;
        inflight_pc <= pc;
      end
      if (push) wptr <= wptr + QW'(1);
      rptr  <= rptr_nxt;
      count <= count_nxt;
    end
  end

  // Queue storage; no reset needed since count gates visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_pc[wptr]  <= inflight_pc;
      q_ins[wptr] <= rdata;
    end
  end

  // Registered head view presented to decode; zero whenever the queue is empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_npc   <= '0;
      out_ins   <= '0;
    end else begin
      out_valid <= valid_nxt;
      out_pc    <= head_pc_nxt;
      out_npc   <= valid_nxt ? head_pc_nxt + INC : '0;
      out_ins   <= head_ins_nxt;
    end
  end

endmodule
